// File: rtl/alu_operand_stage_if.sv
// Request, ALU-side and debug signals of the execute-stage operand front end.
// The master side is the decoder/ALU/debugger environment; the slave side is the stage.
interface alu_operand_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      rs1;
  logic [3:0]      rs2;
  logic [3:0]      rd;
  logic            use_imm;
  logic [XLEN-1:0] imm;
  logic [2:0]      func3;
  logic            f7_bit;
  logic [XLEN-1:0] alu_value1;
  logic [XLEN-1:0] alu_value2;
  logic [2:0]      alu_func_type;
  logic            alu_f7_bit;
  logic [XLEN-1:0] alu_result;
  logic            done;
  logic [XLEN-1:0] result;
  logic [3:0]      dbg_addr;
  logic [XLEN-1:0] dbg_data;

  modport master (
    output in_valid, rs1, rs2, rd, use_imm, imm, func3, f7_bit, alu_result, dbg_addr,
    input  in_ready, alu_value1, alu_value2, alu_func_type, alu_f7_bit, done, result, dbg_data
  );

  modport slave (
    input  in_valid, rs1, rs2, rd, use_imm, imm, func3, f7_bit, alu_result, dbg_addr,
    output in_ready, alu_value1, alu_value2, alu_func_type, alu_f7_bit, done, result, dbg_data
  );
endinterface

// File: rtl/alu_operand_stage.sv
// RV32E execute-stage front end: register file, operand capture for the downstream
// combinational ALU, and result writeback through an IDLE -> EXEC -> WB sequence.
module alu_operand_stage #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_operand_stage_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_EXEC = 2'b01;
  localparam logic [1:0] ST_WB   = 2'b10;

  logic [1:0]      r_state;
  logic [XLEN-1:0] r_regs [NUM_REGS];
  logic [XLEN-1:0] r_value1;
  logic [XLEN-1:0] r_value2;
  logic [2:0]      r_func;
  logic            r_f7;
  logic [3:0]      r_rd;
  logic            r_in_ready;
  logic            r_done;
  logic [XLEN-1:0] r_result;

  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic [XLEN-1:0] w_op2;
  logic            w_f7;

  // ADDI has no funct7 field and shift-left never uses it, so bit 30 is masked there
  function automatic logic qualify_f7(input logic use_imm, input logic [2:0] f3, input logic f7);
    logic q;
    if (f3 == 3'b001) begin
      q = 1'b0;
    end else if (use_imm && (f3 == 3'b000)) begin
      q = 1'b0;
    end else begin
      q = f7;
    end
    return q;
  endfunction

  // Register reads with x0 forced to zero, operand-2 mux and f7 qualification
  always_comb begin
    w_rs1_val = {XLEN{1'b0}};
    w_rs2_val = {XLEN{1'b0}};
    if (bus.rs1 != 4'd0) begin
      w_rs1_val = r_regs[bus.rs1];
    end else begin
      w_rs1_val = {XLEN{1'b0}};
    end
    if (bus.rs2 != 4'd0) begin
      w_rs2_val = r_regs[bus.rs2];
    end else begin
      w_rs2_val = {XLEN{1'b0}};
    end
    w_op2 = bus.use_imm ? bus.imm : w_rs2_val;
    w_f7  = qualify_f7(bus.use_imm, bus.func3, bus.f7_bit);
  end

  // Sequencer, operand capture, writeback and register file state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_value1   <= {XLEN{1'b0}};
      r_value2   <= {XLEN{1'b0}};
      r_func     <= 3'b000;
      r_f7       <= 1'b0;
      r_rd       <= 4'd0;
      r_in_ready <= 1'b1;
      r_done     <= 1'b0;
      r_result   <= {XLEN{1'b0}};
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= {XLEN{1'b0}};
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_value1   <= w_rs1_val;
            r_value2   <= w_op2;
            r_func     <= bus.func3;
            r_f7       <= w_f7;
            r_rd       <= bus.rd;
            r_in_ready <= 1'b0;
            r_state    <= ST_EXEC;
          end else begin
            r_state    <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          // Writes land here so the next accept always reads the new value
          r_result <= bus.alu_result;
          if (r_rd != 4'd0) begin
            r_regs[r_rd] <= bus.alu_result;
          end
          r_done  <= 1'b1;
          r_state <= ST_WB;
        end
        ST_WB: begin
          r_done     <= 1'b0;
          r_in_ready <= 1'b1;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_done     <= 1'b0;
          r_in_ready <= 1'b1;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready      = r_in_ready;
  assign bus.done          = r_done;
  assign bus.result        = r_result;
  assign bus.alu_value1    = r_value1;
  assign bus.alu_value2    = r_value2;
  assign bus.alu_func_type = r_func;
  assign bus.alu_f7_bit    = r_f7;
  assign bus.dbg_data      = (bus.dbg_addr == 4'd0) ? {XLEN{1'b0}} : r_regs[bus.dbg_addr];

endmodule
